hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_pkg.sv | 18 +
 rtl/seg7_decode.sv | 11 +
 rtl/hex_display_ctrl.sv | 113 +++++++++++
 tb/tb_hex_display_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display controller: scan states,
// the active-low segment table and the blank pattern.
package hex_display_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_e;

   localparam logic [6:0] BLANK = 7'h7F;

   // Active-low, segment g in bit 6 and segment a in bit 0.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_decode
   import hex_display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Byte-fed hex display: a nibble buffer refreshed one digit per cycle through
// a single shared decoder into segment registers, with optional blinking.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   output logic                    in_ready,
   input  logic                    clear,
   input  logic                    blink_en,
   output logic                    busy,
   output logic [7*NUM_DIGITS-1:0] hex_out
);

   localparam int unsigned       IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned       CNT_W    = $clog2(BLINK_DIV);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BLINK_DIV - 1);

   state_e           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [3:0]       r_buf [NUM_DIGITS];
   logic [6:0]       r_seg [NUM_DIGITS];
   logic [CNT_W-1:0] r_blink_cnt;
   logic             r_blink_phase;

   logic [3:0]       w_nibble;
   logic [6:0]       w_seg;
   logic             w_clear;
   logic             w_accept;
   logic             w_blank;

   assign in_ready = (r_state == ST_IDLE) && !clear;
   assign busy     = (r_state == ST_SCAN);
   assign w_clear  = (r_state == ST_IDLE) && clear;
   assign w_accept = in_valid && in_ready;
   assign w_nibble = r_buf[r_idx];

   seg7_decode u_seg7_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         for (int k = 0; k < int'(NUM_DIGITS); k++) r_buf[k] <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_clear) begin
                  for (int k = 0; k < int'(NUM_DIGITS); k++) r_buf[k] <= '0;
                  r_idx   <= '0;
                  r_state <= ST_SCAN;
               end else if (w_accept) begin
                  for (int k = 2; k < int'(NUM_DIGITS); k++) r_buf[k] <= r_buf[k-2];
                  r_buf[1] <= in_data[7:4];
                  r_buf[0] <= in_data[3:0];
                  r_idx    <= '0;
                  r_state  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Reset restores the "0" glyph everywhere, discarding any half-finished scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NUM_DIGITS); k++) r_seg[k] <= SEG_TABLE[0];
      end else if (r_state == ST_SCAN) begin
         r_seg[r_idx] <= w_seg;
      end
   end

   // Free-running so blinking resumes in the current phase when re-enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (r_blink_cnt == CNT_MAX) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= !r_blink_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign w_blank = blink_en && !r_blink_phase;

   always_comb begin
      hex_out = '0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         hex_out[k*7 +: 7] = w_blank ? BLANK : r_seg[k];
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized scoreboard bench for hex_display_ctrl with a digit-string reference model.
module tb_hex_display_ctrl;

   localparam int ND = 6;

   localparam logic [6:0] SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          clear;
   logic          blink_en;
   logic          busy;
   logic [41:0]   hex_out;

   int            checks;
   int            errors;
   logic [23:0]   model;
   logic [41:0]   exp_q [$];
   logic          ignore_scan;
   int            n_edges;

   hex_display_ctrl #(
      .NUM_DIGITS (ND),
      .BLINK_DIV  (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .clear    (clear),
      .blink_en (blink_en),
      .busy     (busy),
      .hex_out  (hex_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Posedges since the last reset release, used to predict the blink phase.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n_edges <= 0;
      else        n_edges <= n_edges + 1;
   end

   function automatic logic [41:0] render(input logic [23:0] v);
      logic [41:0] r;
      logic [3:0]  nib;
      r = '0;
      for (int k = 0; k < ND; k++) begin
         nib = v[4*k +: 4];
         r[7*k +: 7] = SEG[nib];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 40) begin
         @(negedge clk);
         t++;
      end
      #1;
      if (busy) chk("wait_idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic write_byte(input logic [7:0] b);
      bit done;
      done = 0;
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 40 && !done; t++) begin
         #1;
         if (in_ready) begin
            model = {model[15:0], b};
            exp_q.push_back(render(model));
            done = 1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!done) chk("write_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_clear(input bit with_valid, input logic [7:0] b);
      bit done;
      done = 0;
      clear    = 1'b1;
      in_valid = with_valid;
      in_data  = b;
      for (int t = 0; t < 40 && !done; t++) begin
         #1;
         if (!busy) begin
            chk("ready_low_under_clear", 64'(in_ready), 64'd0);
            model = '0;
            exp_q.push_back(render(model));
            done = 1;
         end
         @(negedge clk);
      end
      clear = 1'b0;
      if (!done) chk("clear_timeout", 64'd0, 64'd1);
      if (with_valid) write_byte(b);
   endtask

   // Monitor: at every completed scan compare display and scan length.
   initial begin : monitor
      bit          prev_busy;
      int          run;
      logic [41:0] e;
      prev_busy = 0;
      run = 0;
      forever begin
         @(negedge clk);
         #2;
         if (busy) begin
            run++;
         end else begin
            if (prev_busy && !ignore_scan) begin
               chk("scan_length", 64'(run), 64'(ND));
               chk("ready_after_scan", 64'(in_ready), 64'(!clear));
               if (exp_q.size() == 0) begin
                  chk("unexpected_scan", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("display", 64'(hex_out), 64'(e));
               end
            end
            run = 0;
         end
         prev_busy = busy;
      end
   end

   initial begin : stim
      logic [41:0] blank_all;
      bit          exp_blank;
      int          r;
      checks      = 0;
      errors      = 0;
      model       = '0;
      ignore_scan = 1'b0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      clear       = 1'b0;
      blink_en    = 1'b0;
      blank_all   = {6{7'h7F}};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_hex", 64'(hex_out), 64'(render(24'h0)));
      chk("reset_ready", 64'(in_ready), 64'd1);
      chk("reset_busy", 64'(busy), 64'd0);
      @(negedge clk);

      write_byte(8'h3A);
      do_clear(1'b0, 8'h00);
      write_byte(8'h12);
      write_byte(8'h34);
      write_byte(8'h56);
      write_byte(8'h78);
      do_clear(1'b1, 8'hAB);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) do_clear(r[0], 8'h00);
         else        write_byte(8'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      wait_idle();
      repeat (3) @(negedge clk);

      // Blinking with BLINK_DIV=4, then steady data when disabled.
      blink_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         #1;
         exp_blank = ((n_edges / 4) % 2) == 1;
         chk("blink_on", 64'(hex_out), 64'(exp_blank ? blank_all : render(model)));
      end
      blink_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         chk("blink_off", 64'(hex_out), 64'(render(model)));
      end

      // Reset in the middle of a scan of FF.
      ignore_scan = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      #1;
      chk("ff_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("ff_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midscan_reset_hex", 64'(hex_out), 64'(render(24'h0)));
      chk("midscan_reset_busy", 64'(busy), 64'd0);
      chk("midscan_reset_ready", 64'(in_ready), 64'd1);
      model = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("post_reset_hex", 64'(hex_out), 64'(render(24'h0)));
      chk("post_reset_busy", 64'(busy), 64'd0);
      ignore_scan = 1'b0;

      write_byte(8'hC5);
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
